// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings and the read responder state type.
// Imported by the burst address generator and the read slave top.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REQ,
        CAP,
        RESP
    } rd_state_e;

    // WRAP is not supported by this slave, so it is answered like the reserved code.
    function automatic logic burst_err(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [2:0] size_max);
        return (burst == BURST_WRAP) || (burst == BURST_RSVD) || (size > size_max);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Burst address generator: holds the start address, size and burst type of the
// current burst and steps the beat address; also flags unsupported bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] word_addr,
    output logic              err
);

    localparam int LSB = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << LSB) - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_addr;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        next_addr = addr_q;
        if (burst_q == BURST_INCR) begin
            next_addr = addr_q + (ADDR_W'(1) << size_q);
        end

        addr_d  = addr_q;
        size_d  = size_q;
        burst_d = burst_q;
        if (load) begin
            addr_d  = start_addr;
            size_d  = size;
            burst_d = burst;
        end else if (advance) begin
            addr_d  = next_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign word_addr = addr_q & ALIGN_MASK;
    assign err       = burst_err(burst_q, size_q, 3'(LSB));

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read responder (AR/R) in front of a 1-cycle-latency SRAM read port.
// One burst at a time: optional start delay, then REQ/CAP/RESP per beat.
module axi_sram_rd_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SIZE_MAX = $clog2(DATA_W / 8);

    rd_state_e         state_q, state_d;
    logic [3:0]        dly_q, dly_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic ar_fire;
    logic r_fire;
    logic load;
    logic advance;
    logic err;
    logic err_new;

    axi_burst_addr #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .start_addr (araddr),
        .size       (arsize),
        .burst      (arburst),
        .word_addr  (mem_raddr),
        .err        (err)
    );

    assign arready = (state_q == IDLE) & ~rst;
    assign ar_fire = arvalid & arready;
    assign r_fire  = rvalid & rready;
    // The latched err is not visible until after the handshake edge.
    assign err_new = burst_err(arburst, arsize, 3'(SIZE_MAX));

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        beat_d  = beat_q;
        len_d   = len_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    load    = 1'b1;
                    beat_d  = '0;
                    len_d   = arlen;
                    id_d    = arid;
                    rdata_d = '0;
                    if (DELAY > 0) begin
                        state_d = WAIT;
                        dly_d   = 4'(DELAY - 1);
                    end else begin
                        state_d = err_new ? RESP : REQ;
                    end
                end
            end
            WAIT: begin
                if (dly_q == '0) begin
                    state_d = err ? RESP : REQ;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (r_fire) begin
                    if (rlast) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        advance = 1'b1;
                        state_d = err ? RESP : REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
        end
    end

    // Error bursts never capture memory data, so rdata_q stays at its cleared value.
    assign rvalid  = (state_q == RESP);
    assign rlast   = rvalid & (beat_q == len_q);
    assign rresp   = (rvalid & err) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = rdata_q;
    assign rid     = id_q;
    assign mem_ren = (state_q == REQ);

endmodule

// File: doc/axi_sram_rd_slave.md
Name: axi_sram_rd_slave

Overview:
AXI4 read-channel responder (AR/R only) sitting in front of a synchronous instruction/data SRAM model. It is the slave end for the core's fetch and load read masters. It accepts one burst at a time, waits a programmable delay, and walks the burst beat-by-beat through a 1-cycle-latency memory port. Each beat is returned on R with full rvalid/rready backpressure.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; bytes per beat = DATA_W/8
ID_W, 4, transaction ID width
DELAY, 2, idle cycles between AR handshake and first memory request (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  burst start address
arid  in  ID_W  transaction ID
arlen  in  8  beats minus one
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  beat data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat of burst
rid  out  ID_W  echo of latched arid
mem_ren  out  1  memory read strobe
mem_raddr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  memory data, valid the cycle after mem_ren

Behaviour:
- Clock clk; reset rst is synchronous and active-high. While rst=1 or after reset: state IDLE, arready=0 during rst, rvalid=0, rlast=0, rresp=00, rdata=0, rid=0, mem_ren=0, mem_raddr=0, beat counter=0.
- States: IDLE, WAIT, REQ, CAP, RESP.
- arready = (state==IDLE) & ~rst. It is asserted only in IDLE; one outstanding burst max.
- IDLE: on arvalid&arready, latch araddr, arid, arlen, arsize, arburst and set beat counter=0.
  - err = (arburst[1]==1) | (arsize > log2(DATA_W/8)).
  - Next state is WAIT with delay counter=DELAY-1 if DELAY>0, else REQ; if err, RESP instead of REQ.
- WAIT: decrement counter; at 0, go to REQ (or RESP if err).
- REQ: mem_ren=1 for exactly one cycle, mem_raddr=current beat address. Next state CAP.
- CAP: rdata <= mem_rdata at the clock edge. Next state RESP.
- RESP: rvalid=1; rresp=00, or 10 if err with rdata=0; rlast=(beat counter==len); rid=latched id.
  - rdata, rresp, rlast and rid are held stable while rvalid & ~rready.
  - On rvalid&rready with rlast: go to IDLE, and arready rises the next cycle.
  - On rvalid&rready without rlast: increment beat counter, update address, go to REQ (or stay in RESP next cycle if err).
- Latency: for an AR handshake in cycle 0, the first rvalid appears in cycle DELAY+3 (OKAY) or DELAY+1 (err). Inter-beat minimum is 3 cycles (REQ, CAP, RESP).
- Address rules:
  - FIXED: address constant.
  - INCR: address += (1<<arsize), modulo 2^ADDR_W (wraps at top of space, no error).
  - mem_raddr is word-aligned: low log2(DATA_W/8) bits forced to 0.
- Error bursts still return exactly len+1 beats, all SLVERR, with no mem_ren.
- arlen=0: single beat, rlast=1 on the first beat.
- arlen=255: beat counter is 8 bits, and rlast is asserted on the 256th beat.
- arvalid high while not IDLE: ignored; the master must hold it until IDLE.
- Reset mid-burst: abandon the burst at the next edge and enter IDLE; no further R beats; memory is not touched.

Decomposition:
- Shared package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP
  - resp encodings RESP_OKAY/SLVERR
  - the rd_state enum (IDLE, WAIT, REQ, CAP, RESP)
- One sub-module, axi_burst_addr: latches the start address, size and burst type, and produces the current and next beat address plus the err flag. It is purely arithmetic plus one register.

Test Plan:
- DELAY=2, single INCR beat araddr=0x80000000, arsize=2, arlen=0, arid=3; mem returns 0xDEADBEEF -> one mem_ren at 0x80000000; rvalid in cycle 5 after handshake; rdata=0xDEADBEEF, rresp=00, rlast=1, rid=3.
- INCR burst araddr=0x80000010, arlen=3, arsize=2 -> mem_raddr sequence 0x10, 0x14, 0x18, 0x1C (high bits 0x8000000); 4 beats; rlast only on beat 4.
- FIXED burst araddr=0x80000100, arlen=2 -> three mem_ren, all at 0x80000100; 3 beats with rlast on the third.
- Backpressure: rready=0 for 5 cycles during beat 2 of a 4-beat INCR -> rdata/rlast/rid stable; no extra mem_ren; remaining beats correct after release.
- arburst=10 (WRAP), arlen=1 -> zero mem_ren; 2 beats rresp=10, rdata=0, rlast on the second; first rvalid in cycle DELAY+1.
- rst asserted in the RESP state of beat 1 of a 4-beat burst -> next cycle rvalid=0, arready=1 after rst drops; a new AR is accepted and served correctly.
